// File: rtl/core_seq_pkg.sv
// Shared encodings for the RV32 core sequencer: load beat types, FSM states,
// halt reasons and the SYSTEM instructions that stop a run.
package core_seq_pkg;

  typedef enum logic [1:0] {
    LD_INSTR = 2'd0,
    LD_REG   = 2'd1,
    LD_PC    = 2'd2,
    LD_GO    = 2'd3
  } ld_type_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_BOOT = 3'd2,
    ST_RUN  = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    HR_NONE   = 2'd0,
    HR_EBREAK = 2'd1,
    HR_ECALL  = 2'd2,
    HR_LIMIT  = 2'd3
  } halt_reason_e;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [31:0] ECALL_INST  = 32'h0000_0073;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Lifecycle sequencer for the single-cycle RV32 core: program load, reset/boot,
// run with ECALL/EBREAK/budget/abort detection, and halt status reporting.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_ld_valid,
  output logic        o_ld_ready,
  input  logic [1:0]  i_ld_type,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_data,
  output logic        o_core_rst_n,
  output logic        o_setup,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_data,
  output logic [4:0]  o_reg_addr,
  output logic [31:0] o_reg_data,
  output logic [31:0] o_start_pc,
  input  logic [31:0] i_core_inst,
  output logic        o_running,
  output logic        o_done,
  output logic [1:0]  o_halt_reason,
  output logic [31:0] o_cycles,
  output logic        o_err
);

  localparam logic [32:0] IMEM_BYTES  = 33'(IMEM_WORDS) * 33'd4;
  localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES);
  localparam logic [32:0] CYCLE_LIMIT = 33'(MAX_CYCLES);

  state_e       state_reg, state_next;
  logic [31:0]  boot_cnt_reg, boot_cnt_next;
  halt_reason_e halt_reason_reg, halt_reason_next;
  logic         err_reg, err_next;
  logic [31:0]  imem_addr_reg, imem_addr_next;
  logic [31:0]  imem_data_reg, imem_data_next;
  logic [4:0]   reg_addr_reg, reg_addr_next;
  logic [31:0]  reg_data_reg, reg_data_next;
  logic [31:0]  start_pc_reg, start_pc_next;
  logic         ld_ready_reg, core_rst_n_reg, setup_reg, running_reg, done_reg;
  logic         ld_ready_next, core_rst_n_next, setup_next, running_next, done_next;

  logic         cnt_clr, cnt_en;
  logic [31:0]  cycles;
  logic         ld_fire, instr_bad, limit_hit;

  sat_counter #(.W(32)) u_cycles (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cycles)
  );

  assign ld_fire   = i_ld_valid && ld_ready_reg;
  assign instr_bad = (i_ld_addr[1:0] != 2'b00) || ({1'b0, i_ld_addr} >= IMEM_BYTES);
  // Compared one ahead so the halt lands on the cycle that reaches the budget.
  assign limit_hit = (MAX_CYCLES != 0) && (({1'b0, cycles} + 33'd1) == CYCLE_LIMIT);

  always_comb begin
    state_next       = state_reg;
    boot_cnt_next    = boot_cnt_reg;
    halt_reason_next = halt_reason_reg;
    err_next         = err_reg;
    imem_addr_next   = imem_addr_reg;
    imem_data_next   = imem_data_reg;
    reg_addr_next    = reg_addr_reg;
    reg_data_next    = reg_data_reg;
    start_pc_next    = start_pc_reg;
    cnt_clr          = 1'b0;
    cnt_en           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (ld_fire) begin
          case (ld_type_e'(i_ld_type))
            LD_INSTR: begin
              if (instr_bad) begin
                err_next = 1'b1;
              end else begin
                imem_addr_next = i_ld_addr;
                imem_data_next = i_ld_data;
              end
            end
            LD_REG: begin
              // x0 is hardwired in the core; writing it is pointless, not wrong
              if (i_ld_addr[4:0] != 5'd0) begin
                reg_addr_next = i_ld_addr[4:0];
                reg_data_next = i_ld_data;
              end
            end
            LD_PC: begin
              start_pc_next = i_ld_data;
              if (i_ld_data[1:0] != 2'b00) err_next = 1'b1;
            end
            default: begin
              state_next    = ST_BOOT;
              boot_cnt_next = '0;
            end
          endcase
        end
      end
      ST_BOOT: begin
        if (boot_cnt_reg == RST_LAST) begin
          state_next = ST_RUN;
        end else begin
          boot_cnt_next = boot_cnt_reg + 32'd1;
        end
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (i_abort) begin
          state_next       = ST_HALT;
          halt_reason_next = HR_LIMIT;
        end else if (i_core_inst == EBREAK_INST) begin
          state_next       = ST_HALT;
          halt_reason_next = HR_EBREAK;
        end else if (i_core_inst == ECALL_INST) begin
          state_next       = ST_HALT;
          halt_reason_next = HR_ECALL;
        end else if (limit_hit) begin
          state_next       = ST_HALT;
          halt_reason_next = HR_LIMIT;
        end
      end
      ST_HALT: begin
        if (i_start) begin
          state_next       = ST_LOAD;
          cnt_clr          = 1'b1;
          halt_reason_next = HR_NONE;
          err_next         = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    ld_ready_next   = (state_next == ST_LOAD);
    setup_next      = (state_next != ST_RUN);
    running_next    = (state_next == ST_RUN);
    done_next       = (state_next == ST_HALT);
    core_rst_n_next = (state_next == ST_RUN) || (state_next == ST_HALT) ||
                      ((state_next == ST_BOOT) && (boot_cnt_next == RST_LAST));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      boot_cnt_reg    <= '0;
      halt_reason_reg <= HR_NONE;
      err_reg         <= 1'b0;
      imem_addr_reg   <= '0;
      imem_data_reg   <= '0;
      reg_addr_reg    <= '0;
      reg_data_reg    <= '0;
      start_pc_reg    <= '0;
      ld_ready_reg    <= 1'b0;
      core_rst_n_reg  <= 1'b0;
      setup_reg       <= 1'b1;
      running_reg     <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      boot_cnt_reg    <= boot_cnt_next;
      halt_reason_reg <= halt_reason_next;
      err_reg         <= err_next;
      imem_addr_reg   <= imem_addr_next;
      imem_data_reg   <= imem_data_next;
      reg_addr_reg    <= reg_addr_next;
      reg_data_reg    <= reg_data_next;
      start_pc_reg    <= start_pc_next;
      ld_ready_reg    <= ld_ready_next;
      core_rst_n_reg  <= core_rst_n_next;
      setup_reg       <= setup_next;
      running_reg     <= running_next;
      done_reg        <= done_next;
    end
  end

  assign o_ld_ready    = ld_ready_reg;
  assign o_core_rst_n  = core_rst_n_reg;
  assign o_setup       = setup_reg;
  assign o_imem_addr   = imem_addr_reg;
  assign o_imem_data   = imem_data_reg;
  assign o_reg_addr    = reg_addr_reg;
  assign o_reg_data    = reg_data_reg;
  assign o_start_pc    = start_pc_reg;
  assign o_running     = running_reg;
  assign o_done        = done_reg;
  assign o_halt_reason = halt_reason_reg;
  assign o_cycles      = cycles;
  assign o_err         = err_reg;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl: stimulus queues expectations, a monitor
// compares them when load beats, boot completion, halts or probes occur.
module tb_core_seq_ctrl;
  import core_seq_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_abort, i_ld_valid, o_ld_ready;
  logic [1:0]  i_ld_type;
  logic [31:0] i_ld_addr, i_ld_data;
  logic        o_core_rst_n, o_setup;
  logic [31:0] o_imem_addr, o_imem_data, o_reg_data, o_start_pc, i_core_inst;
  logic [4:0]  o_reg_addr;
  logic        o_running, o_done, o_err;
  logic [1:0]  o_halt_reason;
  logic [31:0] o_cycles;

  always #5 clk = ~clk;

  core_seq_ctrl #(.IMEM_WORDS(256), .RST_CYCLES(2), .MAX_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_type(i_ld_type),
    .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data), .o_core_rst_n(o_core_rst_n),
    .o_setup(o_setup), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .o_reg_addr(o_reg_addr), .o_reg_data(o_reg_data), .o_start_pc(o_start_pc),
    .i_core_inst(i_core_inst), .o_running(o_running), .o_done(o_done),
    .o_halt_reason(o_halt_reason), .o_cycles(o_cycles), .o_err(o_err)
  );

  // Minimal core stand-in: PC reloads while in reset, advances only out of setup.
  logic [31:0] prog [0:255];
  logic [31:0] pc;
  always @(posedge clk) begin
    if (!o_core_rst_n) pc <= o_start_pc;
    else if (!o_setup) pc <= pc + 32'd4;
  end
  assign i_core_inst = prog[pc[9:2]];

  typedef struct {
    logic [31:0] imem_addr, imem_data, reg_data, start_pc;
    logic [4:0]  reg_addr;
    logic        err;
  } ld_exp_t;
  typedef struct {
    logic [1:0]  reason;
    logic [31:0] cycles;
    logic        err;
  } halt_exp_t;
  typedef struct {
    string       name;
    logic        ready, rst_n, setup, running, done, err;
    logic [1:0]  reason;
    logic [31:0] cycles;
  } probe_t;

  ld_exp_t   ld_q[$];
  halt_exp_t halt_q[$];
  probe_t    probe_q[$];
  int        boot_q[$];

  int n_checks = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void flag(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event, want expected event", name);
  endfunction

  // Expected load-output registers as the bench believes them to be.
  ld_exp_t m;

  task automatic model_clear();
    m.imem_addr = '0; m.imem_data = '0; m.reg_addr = '0;
    m.reg_data = '0; m.start_pc = '0; m.err = 1'b0;
  endtask

  task automatic probe(input string name, input logic ready, input logic rst_n,
                       input logic setup, input logic running, input logic done,
                       input logic [1:0] reason, input logic [31:0] cycles,
                       input logic err);
    probe_t p;
    p.name = name; p.ready = ready; p.rst_n = rst_n; p.setup = setup;
    p.running = running; p.done = done; p.reason = reason; p.cycles = cycles;
    p.err = err;
    probe_q.push_back(p);
  endtask

  task automatic expect_halt(input logic [1:0] reason, input logic [31:0] cycles,
                             input logic err);
    halt_exp_t h;
    h.reason = reason; h.cycles = cycles; h.err = err;
    halt_q.push_back(h);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    m.err = 1'b0;
  endtask

  task automatic send(input logic [1:0] typ, input logic [31:0] addr,
                      input logic [31:0] data);
    bit got = 1'b0;
    case (typ)
      LD_INSTR: begin
        if (addr[1:0] != 2'b00 || addr >= 32'h400) m.err = 1'b1;
        else begin
          m.imem_addr = addr; m.imem_data = data; prog[addr[9:2]] = data;
        end
      end
      LD_REG: if (addr[4:0] != 5'd0) begin m.reg_addr = addr[4:0]; m.reg_data = data; end
      LD_PC: begin
        m.start_pc = data;
        if (data[1:0] != 2'b00) m.err = 1'b1;
      end
      default: boot_q.push_back(2);
    endcase
    ld_q.push_back(m);
    i_ld_type = typ; i_ld_addr = addr; i_ld_data = data; i_ld_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_ld_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      flag("ld_handshake");
      void'(ld_q.pop_back());
    end
    @(posedge clk); #1 i_ld_valid = 1'b0;
  endtask

  task automatic wait_running();
    bit got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_running) begin got = 1'b1; break; end
    end
    if (!got) flag("wait_running");
  endtask

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_done) begin got = 1'b1; break; end
    end
    if (!got) begin
      flag(name);
      if (halt_q.size() > 0) void'(halt_q.pop_back());
    end
    @(posedge clk); #1;
  endtask

  // Monitor state
  ld_exp_t   mon_le;
  halt_exp_t mon_he;
  probe_t    mon_p;
  int        mon_bexp;
  logic      mon_pend = 1'b0, prev_ready = 1'b0, prev_done = 1'b0, boot_phase = 1'b0;
  int        zeros = 0, ones = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (probe_q.size() > 0) begin
        mon_p = probe_q.pop_front();
        chk({mon_p.name, ".ready"},   32'(o_ld_ready),    32'(mon_p.ready));
        chk({mon_p.name, ".rst_n"},   32'(o_core_rst_n),  32'(mon_p.rst_n));
        chk({mon_p.name, ".setup"},   32'(o_setup),       32'(mon_p.setup));
        chk({mon_p.name, ".running"}, 32'(o_running),     32'(mon_p.running));
        chk({mon_p.name, ".done"},    32'(o_done),        32'(mon_p.done));
        chk({mon_p.name, ".reason"},  32'(o_halt_reason), 32'(mon_p.reason));
        chk({mon_p.name, ".cycles"},  o_cycles,           mon_p.cycles);
        chk({mon_p.name, ".err"},     32'(o_err),         32'(mon_p.err));
      end
      if (mon_pend) begin
        chk("ld.imem_addr", o_imem_addr,       mon_le.imem_addr);
        chk("ld.imem_data", o_imem_data,       mon_le.imem_data);
        chk("ld.reg_addr",  32'(o_reg_addr),   32'(mon_le.reg_addr));
        chk("ld.reg_data",  o_reg_data,        mon_le.reg_data);
        chk("ld.start_pc",  o_start_pc,        mon_le.start_pc);
        chk("ld.err",       32'(o_err),        32'(mon_le.err));
        mon_pend = 1'b0;
      end
      if (i_ld_valid && o_ld_ready) begin
        if (ld_q.size() == 0) flag("unexpected_accept");
        else begin mon_le = ld_q.pop_front(); mon_pend = 1'b1; end
      end
      if (rst) begin
        boot_phase = 1'b0;
      end else begin
        if (prev_ready && !o_ld_ready) begin boot_phase = 1'b1; zeros = 0; ones = 0; end
        if (boot_phase) begin
          if (o_running) begin
            boot_phase = 1'b0;
            if (boot_q.size() == 0) flag("unexpected_boot");
            else begin
              mon_bexp = boot_q.pop_front();
              chk("boot.rst_low_cycles",  32'(zeros), 32'(mon_bexp));
              chk("boot.rst_high_cycles", 32'(ones),  32'd1);
            end
          end else if (o_core_rst_n) ones++;
          else zeros++;
        end
      end
      if (o_done && !prev_done) begin
        if (halt_q.size() == 0) flag("unexpected_halt");
        else begin
          mon_he = halt_q.pop_front();
          chk("halt.reason",  32'(o_halt_reason), 32'(mon_he.reason));
          chk("halt.cycles",  o_cycles,           mon_he.cycles);
          chk("halt.err",     32'(o_err),         32'(mon_he.err));
          chk("halt.running", 32'(o_running),     32'd0);
          chk("halt.setup",   32'(o_setup),       32'd1);
        end
      end
      prev_ready = o_ld_ready;
      prev_done  = o_done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ld_valid = 1'b0;
    i_ld_type = '0; i_ld_addr = '0; i_ld_data = '0;
    for (int i = 0; i < 256; i++) prog[i] = NOP;
    model_clear();
    probe("reset", 0, 0, 1, 0, 0, 2'd0, 32'd0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Two-instruction program ending in EBREAK
    pulse_start();
    send(LD_INSTR, 32'h0, 32'h0050_0093);
    send(LD_INSTR, 32'h4, EBREAK_INST);
    send(LD_PC, 32'h0, 32'h0);
    expect_halt(2'd1, 32'd2, 1'b0);
    send(LD_GO, 32'h0, 32'h0);
    wait_done("wait_ebreak_halt");

    // Register preloads, bad instruction addresses, ECALL halt keeps error
    pulse_start();
    probe("restart_after_ebreak", 1, 0, 1, 0, 0, 2'd0, 32'd0, 0);
    send(LD_REG, 32'd0, 32'h0000_DEAD);
    send(LD_REG, 32'd5, 32'h0000_1234);
    send(LD_INSTR, 32'h2, 32'hFFFF_FFFF);
    send(LD_INSTR, 32'h400, 32'hEEEE_EEEE);
    send(LD_INSTR, 32'hC0, NOP);
    send(LD_INSTR, 32'hC4, ECALL_INST);
    send(LD_PC, 32'h0, 32'hC0);
    expect_halt(2'd2, 32'd2, 1'b1);
    send(LD_GO, 32'h0, 32'h0);
    wait_done("wait_ecall_halt");

    // NOP program hits the 10-cycle budget; a stray start in RUN is ignored
    pulse_start();
    probe("restart_after_ecall", 1, 0, 1, 0, 0, 2'd0, 32'd0, 0);
    for (int a = 'h40; a <= 'h4C; a += 4) send(LD_INSTR, 32'(a), NOP);
    send(LD_PC, 32'h0, 32'h40);
    expect_halt(2'd3, 32'd10, 1'b0);
    send(LD_GO, 32'h0, 32'h0);
    wait_running();
    i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    wait_done("wait_limit_halt");

    // Abort and EBREAK in the same cycle; misaligned PC flags error
    pulse_start();
    send(LD_INSTR, 32'h80, EBREAK_INST);
    send(LD_PC, 32'h0, 32'h82);
    send(LD_PC, 32'h0, 32'h80);
    i_abort = 1'b1;
    expect_halt(2'd3, 32'd1, 1'b1);
    send(LD_GO, 32'h0, 32'h0);
    wait_done("wait_abort_halt");
    i_abort = 1'b0;
    pulse_start();
    probe("restart_after_abort", 1, 0, 1, 0, 0, 2'd0, 32'd0, 0);

    // Asynchronous reset in the middle of a run
    send(LD_PC, 32'h0, 32'h40);
    send(LD_GO, 32'h0, 32'h0);
    wait_running();
    @(posedge clk); #2 rst = 1'b1;
    model_clear();
    probe("rst_in_run", 0, 0, 1, 0, 0, 2'd0, 32'd0, 0);
    i_ld_type = LD_INSTR; i_ld_addr = 32'h0; i_ld_data = 32'h0000_0BAD; i_ld_valid = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      probe("idle_no_accept", 0, 0, 1, 0, 0, 2'd0, 32'd0, 0);
      @(posedge clk); #1;
    end
    i_ld_valid = 1'b0;
    pulse_start();
    probe("start_from_idle", 1, 0, 1, 0, 0, 2'd0, 32'd0, 0);
    send(LD_REG, 32'd7, 32'h0000_0077);

    repeat (3) @(posedge clk);
    #1;
    chk("ld_queue_drained",    32'(ld_q.size()),    32'd0);
    chk("halt_queue_drained",  32'(halt_q.size()),  32'd0);
    chk("boot_queue_drained",  32'(boot_q.size()),  32'd0);
    chk("probe_queue_drained", 32'(probe_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
